// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and receive-FSM state type for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_W     = 8;
    localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: valid/ready read port of the scan-code FIFO.
//   rd_valid : FIFO non-empty (driven by master)
//   rd_ready : consumer accepts rd_data this cycle (driven by slave)
//   rd_data  : FIFO head byte (driven by master)
interface ps2_kbd_rx_if;
    import ps2_pkg::*;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [PS2_DATA_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous FIFO with combinational head.
//   i_push/i_wr_data : write; ignored when full unless a pop happens in the same cycle
//   i_pop            : read; ignored when empty
//   o_rd_data_c      : head entry, or the last popped entry while empty
//   o_full_c/o_empty_c/o_count : occupancy
module ps2_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_pop;
    logic             w_push;

    assign o_empty_c = (r_count == '0);
    assign o_full_c  = (r_count == CW'(DEPTH));
    assign w_pop     = i_pop & ~o_empty_c;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_push    = i_push & (~o_full_c | w_pop);
    assign o_count   = r_count;
    assign o_rd_data_c = o_empty_c ? r_last : r_mem[r_rd_ptr];

    // Storage array, no reset needed: never read before written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and last-read holder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver feeding a scan-code FIFO and a nibble display latch.
//   clk, rst           : system clock, async active-high reset
//   ps2_clk, ps2_data  : raw PS/2 pins (asynchronous)
//   rd                 : FIFO read port (valid/ready), master side
//   code_lo/code_hi    : last good scan code nibbles; code_seen once any good code arrived
//   frame_err          : 1-cycle pulse on bad start/parity/stop or inter-bit timeout
//   overflow           : sticky, a good byte was dropped on a full FIFO
// Optional: define PS2_BREAK_FILTER_EN to drop F0 and the byte following it.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master rd,
    output logic [3:0]   code_lo,
    output logic [3:0]   code_hi,
    output logic         code_seen,
    output logic         frame_err,
    output logic         overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam int unsigned BW = $clog2(PS2_FRAME_BITS);
    localparam int unsigned FB = PS2_FRAME_BITS;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fall;

    rx_state_e              r_state;
    rx_state_e              w_state_nxt;
    logic [BW-1:0]          r_bit_cnt;
    logic [BW-1:0]          w_bit_cnt_nxt;
    logic [FB-2:0]          r_shift;
    logic [FB-2:0]          w_shift_nxt;
    logic [FB-1:0]          w_frame;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timer_nxt;
    logic                   w_good_nxt;
    logic                   w_err_nxt;
    logic                   r_good;
    logic                   r_err;

    logic [PS2_DATA_W-1:0]  w_byte;
    logic [PS2_DATA_W-1:0]  r_code;
    logic                   r_seen;
    logic                   r_ovf;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    logic [PS2_DATA_W-1:0]  w_rd_data;

    // Pin synchronisers, reset to the PS/2 idle level so reset never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    // Incoming bit joins the top; after the stop bit r_shift = {stop, parity, data}
    assign w_frame = {w_dat_s, r_shift};
    assign w_byte  = r_shift[PS2_DATA_W-1:0];

    // Receive FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_timer   <= '0;
            r_good    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_timer   <= w_timer_nxt;
            r_good    <= w_good_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Receive FSM next state: bit capture, frame check and inter-bit timeout
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_timer_nxt   = '0;
        w_good_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = ST_RECV;
                    w_bit_cnt_nxt = BW'(1);
                    w_shift_nxt   = w_frame[FB-1:1];
                end
            end
            ST_RECV: begin
                if (w_fall) begin
                    w_shift_nxt = w_frame[FB-1:1];
                    if (r_bit_cnt == BW'(FB - 1)) begin
                        w_state_nxt   = ST_IDLE;
                        w_bit_cnt_nxt = '0;
                        // start low, stop high, odd parity over data+parity
                        if (!w_frame[0] && w_frame[FB-1] && (^w_frame[FB-2:1])) begin
                            w_good_nxt = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

`ifdef PS2_BREAK_FILTER_EN
    logic r_skip;

    // Break prefix arms a one-shot skip so the released-key code is swallowed too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skip <= 1'b0;
        end else if (r_err) begin
            r_skip <= 1'b0;
        end else if (r_good) begin
            r_skip <= ~r_skip & (w_byte == PS2_BREAK_CODE);
        end
    end

    assign w_accept = r_good & ~r_skip & (w_byte != PS2_BREAK_CODE);
`else
    assign w_accept = r_good;
`endif

    assign w_pop  = rd.rd_ready & ~w_empty;
    assign w_drop = w_accept & w_full & ~w_pop;

    // Display latch and sticky overflow; display updates even when the byte is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= '0;
            r_seen <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_code <= w_byte;
                r_seen <= 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_pop       (w_pop),
        .i_wr_data   (w_byte),
        .o_rd_data_c (w_rd_data),
        .o_full_c    (w_full),
        .o_empty_c   (w_empty),
        .o_count     (w_count)
    );

    assign rd.rd_valid = (w_count != '0);
    assign rd.rd_data  = w_rd_data;
    assign code_lo     = r_code[3:0];
    assign code_hi     = r_code[7:4];
    assign code_seen   = r_seen;
    assign frame_err   = r_err;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed PS/2 frames against a queue-based reference model of the receiver.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned TMO   = 400;
    localparam int unsigned HALF  = 6;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] code_lo;
    logic [3:0] code_hi;
    logic       code_seen;
    logic       frame_err;
    logic       overflow;

    ps2_kbd_rx_if rd ();

    ps2_kbd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd        (rd),
        .code_lo   (code_lo),
        .code_hi   (code_hi),
        .code_seen (code_seen),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: expected FIFO contents, display latch, sticky flags
    logic [7:0] m_q[$];
    logic [7:0] m_code      = '0;
    logic       m_seen      = 1'b0;
    logic       m_ovf       = 1'b0;
    logic       m_skip      = 1'b0;
    logic       m_pend      = 1'b0;
    logic [7:0] m_pend_byte = '0;
    int         m_pend_due  = 0;

    int   err_rise = 0;
    int   err_hi   = 0;
    logic err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_code = '0;
        m_seen = 1'b0;
        m_ovf  = 1'b0;
        m_skip = 1'b0;
        m_pend = 1'b0;
    endtask

    // A byte lands 2 cycles after its stop-bit edge leaves the synchroniser
    always @(posedge clk) begin
        int unsigned sz;
        logic        pop_now;
        logic        take;
        cyc++;
        if (!rst) begin
            sz      = m_q.size();
            pop_now = (sz != 0) && rd.rd_ready;
            take    = 1'b0;
            if (m_pend && cyc == m_pend_due) begin
                m_pend = 1'b0;
                take   = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                if (m_skip) begin
                    m_skip = 1'b0;
                    take   = 1'b0;
                end else if (m_pend_byte == 8'hF0) begin
                    m_skip = 1'b1;
                    take   = 1'b0;
                end
`endif
            end
            if (pop_now) void'(m_q.pop_front());
            if (take) begin
                m_code = m_pend_byte;
                m_seen = 1'b1;
                if (sz < DEPTH || pop_now) m_q.push_back(m_pend_byte);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    always begin
        @(posedge clk);
        #2;
        chk("rd_valid", 32'(rd.rd_valid), 32'(m_q.size() != 0));
        if (rst) chk("rd_data_in_reset", 32'(rd.rd_data), 32'(0));
        else if (m_q.size() != 0) chk("rd_data", 32'(rd.rd_data), 32'(m_q[0]));
        chk("code_lo", 32'(code_lo), 32'(m_code[3:0]));
        chk("code_hi", 32'(code_hi), 32'(m_code[7:4]));
        chk("code_seen", 32'(code_seen), 32'(m_seen));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (frame_err === 1'b1) begin
            err_hi++;
            if (!err_prev) err_rise++;
        end
        err_prev = frame_err;
    end

    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Drive n bits of a frame; on the stop bit tell the model what must arrive
    task automatic send_bits(input logic [10:0] bits, input int n, input logic collide);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                if (!bits[0] && bits[10] && (^bits[9:1])) begin
                    m_pend      = 1'b1;
                    m_pend_byte = bits[8:1];
                    m_pend_due  = cyc + int'(SYNC) + 2;
                end else begin
                    m_skip = 1'b0;
                end
            end
            if (collide && i == 10) begin
                repeat (SYNC + 1) @(negedge clk);
                rd.rd_ready = 1'b1;
                @(negedge clk);
                rd.rd_ready = 1'b0;
                repeat (HALF - SYNC - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk(b, 1'b0), 11, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        rd.rd_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string name, input logic [7:0] exp_q[$]);
        foreach (exp_q[k]) begin
            @(negedge clk);
            chk({name, "_valid"}, 32'(rd.rd_valid), 32'(1));
            chk({name, "_data"}, 32'(rd.rd_data), 32'(exp_q[k]));
            rd.rd_ready = 1'b1;
        end
        @(negedge clk);
        rd.rd_ready = 1'b0;
        chk({name, "_empty"}, 32'(rd.rd_valid), 32'(0));
    endtask

    initial begin
        logic [7:0] exp[$];
        int         e0;
        rst         = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        rd.rd_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_rd_valid", 32'(rd.rd_valid), 32'(0));
        chk("reset_rd_data", 32'(rd.rd_data), 32'(0));
        chk("reset_code_seen", 32'(code_seen), 32'(0));
        chk("reset_overflow", 32'(overflow), 32'(0));
        chk("reset_frame_err", 32'(frame_err), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good frame
        e0 = err_rise;
        send(8'h1C);
        chk("t1_valid", 32'(rd.rd_valid), 32'(1));
        chk("t1_data", 32'(rd.rd_data), 32'h1C);
        chk("t1_code_hi", 32'(code_hi), 32'h1);
        chk("t1_code_lo", 32'(code_lo), 32'hC);
        chk("t1_seen", 32'(code_seen), 32'(1));
        chk("t1_no_err", 32'(err_rise - e0), 32'(0));
        exp = {8'h1C};
        drain("t1_drain", exp);

        // Bad parity, then a good frame
        do_reset();
        e0 = err_rise;
        send_bits(mk(8'h1C, 1'b1), 11, 1'b0);
        repeat (6) @(negedge clk);
        chk("t2_err_pulses", 32'(err_rise - e0), 32'(1));
        chk("t2_valid", 32'(rd.rd_valid), 32'(0));
        chk("t2_seen", 32'(code_seen), 32'(0));
        send(8'h32);
        chk("t2_data", 32'(rd.rd_data), 32'h32);
        exp = {8'h32};
        drain("t2_drain", exp);

        // Timeout mid-frame, then recovery
        e0 = err_rise;
        send_bits(mk(8'h45, 1'b0), 4, 1'b0);
        repeat (TMO + 10) @(negedge clk);
        m_skip = 1'b0;
        chk("t3_err_pulses", 32'(err_rise - e0), 32'(1));
        chk("t3_valid", 32'(rd.rd_valid), 32'(0));
        send(8'h45);
        chk("t3_data", 32'(rd.rd_data), 32'h45);
        exp = {8'h45};
        drain("t3_drain", exp);

        // Overflow on the ninth byte
        for (int b = 1; b <= 9; b++) send(8'(b));
        chk("t4_overflow", 32'(overflow), 32'(1));
        chk("t4_code_lo", 32'(code_lo), 32'h9);
        chk("t4_code_hi", 32'(code_hi), 32'h0);
        exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        drain("t4_drain", exp);
        chk("t4_overflow_sticky", 32'(overflow), 32'(1));

        // Push and pop together on a full FIFO
        do_reset();
        for (int b = 0; b < 8; b++) send(8'h10 + 8'(b));
        send_bits(mk(8'hAA, 1'b0), 11, 1'b1);
        repeat (4) @(negedge clk);
        chk("t5_no_overflow", 32'(overflow), 32'(0));
        chk("t5_code_hi", 32'(code_hi), 32'hA);
        exp = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
        drain("t5_drain", exp);

        // Reset in the middle of a frame
        do_reset();
        send(8'h5A);
        chk("t6_pre_valid", 32'(rd.rd_valid), 32'(1));
        send_bits(mk(8'h77, 1'b0), 5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        chk("t6_rst_valid", 32'(rd.rd_valid), 32'(0));
        chk("t6_rst_data", 32'(rd.rd_data), 32'(0));
        chk("t6_rst_seen", 32'(code_seen), 32'(0));
        chk("t6_rst_code", 32'({code_hi, code_lo}), 32'(0));
        chk("t6_rst_ovf", 32'(overflow), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h29);
        chk("t6_data", 32'(rd.rd_data), 32'h29);
        exp = {8'h29};
        drain("t6_drain", exp);

        // Break sequence handling
        do_reset();
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        chk("t7_code", 32'({code_hi, code_lo}), 32'h1C);
`ifdef PS2_BREAK_FILTER_EN
        exp = {8'h1C};
`else
        exp = {8'h1C, 8'hF0, 8'h1C};
`endif
        drain("t7_drain", exp);

        chk("frame_err_width", 32'(err_hi), 32'(err_rise));
        chk("frame_err_total", 32'(err_rise), 32'(2));
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
